bram_stream_reader: RTL and testbench

Upstream feeder for the M00 AXI-Stream master adapter. On a START command it reads LEN consecutive words from a BRAM port with 1-cycle read latency. It presents them on a valid/accept word interface (DOUT/DOUT_VALID/LAST/DOUT_ACCEP) that connects directly to the adapter's DIN_FROM_BUF/DIN_VALID/last/DIN_ACCEP. A 2-entry output buffer absorbs downstream backpressure without losing in-flight BRAM reads.

---
 rtl/bram_stream_reader_if.sv | 30 +++
 rtl/bram_stream_reader.sv | 122 ++++++++++++
 tb/tb_bram_stream_reader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM read-port and word-stream signals of bram_stream_reader.
// Signal prefixes (i_/o_) are seen from the reader, which uses the master modport.
interface bram_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [LEN_W-1:0]  i_len;
  logic              o_busy;
  logic              o_done;
  logic              o_bram_en;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] i_bram_rddata;
  logic [DATA_W-1:0] o_dout;
  logic              o_dout_valid;
  logic              o_last;
  logic              i_dout_accep;

  modport master (
    input  i_start, i_base_addr, i_len, i_bram_rddata, i_dout_accep,
    output o_busy, o_done, o_bram_en, o_bram_addr, o_dout, o_dout_valid, o_last
  );

  modport slave (
    output i_start, i_base_addr, i_len, i_bram_rddata, i_dout_accep,
    input  o_busy, o_done, o_bram_en, o_bram_addr, o_dout, o_dout_valid, o_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams LEN words from a 1-cycle-latency BRAM; first word valid 3 cycles after START.
// A 2-entry FIFO absorbs stalls; reads are throttled so buffered + in-flight words never exceed 2.
module bram_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  bram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic              r_inflight;
  logic              r_inflight_last;

  logic [DATA_W-1:0] r_fifo_dat [2];
  logic [1:0]        r_fifo_last;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic       w_start_acc;
  logic       w_pop;
  logic       w_issue;
  logic       w_final_read;
  logic       w_drained;
  logic [1:0] w_occupancy;

  assign w_start_acc  = (r_state == S_IDLE) && bus.i_start;
  assign w_pop        = (r_count != 2'd0) && bus.i_dout_accep;
  assign w_occupancy  = r_count + {1'b0, r_inflight};
  assign w_final_read = (r_issued == r_len - LEN_ONE);
  // A handshake this cycle frees a slot, so a read may go out even at full occupancy.
  assign w_issue      = (r_state == S_RUN) && (r_issued != r_len) &&
                        ((w_occupancy < 2'd2) || w_pop);
  assign w_drained    = !r_inflight &&
                        ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An empty transfer passes through DRAIN so DONE still lands two cycles after START.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = (bus.i_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (w_issue && w_final_read) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_FIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_addr          <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_final_read;
      if (w_start_acc) begin
        r_addr   <= bus.i_base_addr;
        r_len    <= bus.i_len;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_issued <= r_issued + LEN_ONE;
      end
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_fifo_dat[0] <= '0;
      r_fifo_dat[1] <= '0;
      r_fifo_last   <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_dat[r_wptr]  <= bus.i_bram_rddata;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.o_done       = (r_state == S_FIN);
  assign bus.o_bram_en    = w_issue;
  assign bus.o_bram_addr  = r_addr;
  assign bus.o_dout       = r_fifo_dat[r_rptr];
  assign bus.o_dout_valid = (r_count != 2'd0);
  assign bus.o_last       = r_fifo_last[r_rptr] && (r_count != 2'd0);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: expected streams are built from base/len/offset arithmetic and
// compared against handshakes, BRAM reads and DONE timing logged at the falling edge.
module tb_bram_stream_reader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;

  logic        clk    = 1'b0;
  logic        areset = 1'b1;
  int          cyc    = 0;
  int          t0     = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned mem_ofs = 32'h100;

  bram_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  bram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_aclk   (clk),
    .i_areset (areset),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM content is the address plus a per-test offset, one cycle of read latency.
  always @(posedge clk) begin
    if (bus.o_bram_en === 1'b1) bus.i_bram_rddata <= DATA_W'(bus.o_bram_addr) + DATA_W'(mem_ofs);
  end

  logic [ADDR_W-1:0] en_addr[$];
  int                en_cyc[$];
  logic [DATA_W-1:0] hs_dat[$];
  logic              hs_last[$];
  int                hs_cyc[$];
  int                done_cyc[$];
  int                busy_n, first_vld, stab_viol, max_ahead, last_stray;
  logic [DATA_W-1:0] first_dat, p_dat;
  logic              p_vld = 1'b0, p_acc = 1'b0, p_last = 1'b0;

  always @(negedge clk) begin
    if (areset) begin
      p_vld = 1'b0;
    end else begin
      if (bus.o_bram_en) begin
        en_addr.push_back(bus.o_bram_addr);
        en_cyc.push_back(cyc - t0);
      end
      if (bus.o_dout_valid && bus.i_dout_accep) begin
        hs_dat.push_back(bus.o_dout);
        hs_last.push_back(bus.o_last);
        hs_cyc.push_back(cyc - t0);
      end
      if (bus.o_dout_valid && first_vld < 0) begin
        first_vld = cyc - t0;
        first_dat = bus.o_dout;
      end
      if (bus.o_done) done_cyc.push_back(cyc - t0);
      if (bus.o_busy) busy_n++;
      if (bus.o_last && !bus.o_dout_valid) last_stray++;
      if (p_vld && !p_acc &&
          (bus.o_dout_valid !== 1'b1 || bus.o_dout !== p_dat || bus.o_last !== p_last)) stab_viol++;
      p_vld  = bus.o_dout_valid;
      p_acc  = bus.i_dout_accep;
      p_dat  = bus.o_dout;
      p_last = bus.o_last;
      if (en_addr.size() - hs_dat.size() > max_ahead) max_ahead = en_addr.size() - hs_dat.size();
    end
  end

  function automatic logic [ADDR_W-1:0] m_addr(int base, int i);
    return ADDR_W'((base + i) % (1 << ADDR_W));
  endfunction

  function automatic logic [DATA_W-1:0] m_word(int base, int i);
    return DATA_W'((base + i) % (1 << ADDR_W)) + DATA_W'(mem_ofs);
  endfunction

  function automatic logic acc_val(int mode, int rel);
    case (mode)
      0:       return 1'b1;
      1:       return !(rel >= 3 && rel <= 8);
      2:       return (rel % 2) == 1;
      default: return $urandom_range(0, 99) < 60;
    endcase
  endfunction

  task automatic clear_logs();
    en_addr.delete(); en_cyc.delete();
    hs_dat.delete(); hs_last.delete(); hs_cyc.delete(); done_cyc.delete();
    busy_n = 0; first_vld = -1; stab_viol = 0; max_ahead = 0; last_stray = 0;
  endtask

  task automatic do_xfer(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                         input int mode, input bit second, output bit timed_out);
    int rel, post, limit;
    limit = int'(len) * 20 + 60;
    rel = 0;
    post = -1;
    timed_out = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    bus.i_start = 1'b1;
    bus.i_base_addr = base;
    bus.i_len = len;
    bus.i_dout_accep = acc_val(mode, 0);
    while (1) begin
      @(posedge clk); #1;
      rel++;
      bus.i_start = (second && rel == 2);
      if (second && rel == 2) begin
        bus.i_base_addr = 10'h155;
        bus.i_len = 16'd9;
      end
      bus.i_dout_accep = acc_val(mode, rel);
      if (post < 0 && done_cyc.size() > 0) post = rel;
      if (post >= 0 && rel >= post + 2) break;
      if (rel > limit) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    checks++; if (bus.o_bram_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.o_bram_en); end
    checks++; if (bus.o_bram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.o_bram_addr); end
    checks++; if (bus.o_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_dout_valid); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.o_last); end
    checks++; if (bus.o_dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.o_dout); end
    areset = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    mem_ofs = 32'h100;
    do_xfer(10'h010, 16'd4, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: no DONE, want DONE"); end
    checks++; if (en_addr.size() != 4) begin errors++; $display("FAIL basic_nreads: got %0d want 4", en_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= en_addr.size() || en_addr[i] !== m_addr(16, i) || en_cyc[i] != 1 + i) begin
        errors++; $display("FAIL basic_addr[%0d]: got %h@%0d want %h@%0d", i, en_addr[i], en_cyc[i], m_addr(16, i), 1 + i);
      end
      checks++;
      if (i >= hs_dat.size() || hs_dat[i] !== m_word(16, i) || hs_cyc[i] != 3 + i || hs_last[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_word[%0d]: got %h@%0d last=%b want %h@%0d last=%b",
                           i, hs_dat[i], hs_cyc[i], hs_last[i], m_word(16, i), 3 + i, (i == 3));
      end
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin errors++; $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=7", done_cyc.size(), done_cyc[0]); end
    checks++; if (busy_n != 6) begin errors++; $display("FAIL basic_busy: got %0d cycles want 6", busy_n); end
    checks++; if (stab_viol != 0 || last_stray != 0) begin errors++; $display("FAIL basic_stable: got %0d/%0d want 0/0", stab_viol, last_stray); end
  endtask

  task automatic test_backpressure();
    bit to;
    mem_ofs = 32'h100;
    do_xfer(10'h010, 16'd4, 1, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: no DONE, want DONE"); end
    checks++; if (first_vld != 3 || first_dat !== 32'h110) begin errors++; $display("FAIL bp_first: got %h@%0d want 110@3", first_dat, first_vld); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol); end
    checks++; if (max_ahead > 2) begin errors++; $display("FAIL bp_ahead: got %0d want <=2", max_ahead); end
    checks++; if (en_addr.size() != 4 || hs_dat.size() != 4) begin errors++; $display("FAIL bp_count: got %0d reads %0d words want 4/4", en_addr.size(), hs_dat.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= hs_dat.size() || hs_dat[i] !== m_word(16, i) || hs_cyc[i] != 9 + i || hs_last[i] !== (i == 3)) begin
        errors++; $display("FAIL bp_word[%0d]: got %h@%0d last=%b want %h@%0d last=%b",
                           i, hs_dat[i], hs_cyc[i], hs_last[i], m_word(16, i), 9 + i, (i == 3));
      end
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 13) begin errors++; $display("FAIL bp_done: got n=%0d cyc=%0d want n=1 cyc=13", done_cyc.size(), done_cyc[0]); end
  endtask

  task automatic test_toggle();
    bit to;
    mem_ofs = 32'h100;
    do_xfer(10'h010, 16'd5, 2, 1'b0, to);
    checks++; if (to || hs_dat.size() != 5) begin errors++; $display("FAIL tog_count: got %0d words to=%b want 5", hs_dat.size(), to); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= hs_dat.size() || hs_dat[i] !== m_word(16, i) || hs_last[i] !== (i == 4)) begin
        errors++; $display("FAIL tog_word[%0d]: got %h last=%b want %h last=%b", i, hs_dat[i], hs_last[i], m_word(16, i), (i == 4));
      end
    end
    checks++;
    if (done_cyc.size() != 1 || hs_cyc.size() != 5 || done_cyc[0] != hs_cyc[4] + 1) begin
      errors++; $display("FAIL tog_done: got cyc=%0d want one cycle after last handshake", done_cyc[0]);
    end
    checks++; if (stab_viol != 0 || last_stray != 0) begin errors++; $display("FAIL tog_stable: got %0d/%0d want 0/0", stab_viol, last_stray); end
  endtask

  task automatic test_wrap();
    bit to;
    mem_ofs = 32'h100;
    do_xfer(10'h3FE, 16'd4, 0, 1'b0, to);
    checks++; if (to || en_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d reads to=%b want 4", en_addr.size(), to); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= en_addr.size() || en_addr[i] !== m_addr(10'h3FE, i) || hs_dat[i] !== m_word(10'h3FE, i)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h/%h want %h/%h", i, en_addr[i], hs_dat[i], m_addr(10'h3FE, i), m_word(10'h3FE, i));
      end
    end
  endtask

  task automatic test_len0();
    bit to;
    do_xfer(10'h010, 16'd0, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL len0_timeout: no DONE, want DONE"); end
    checks++; if (en_addr.size() != 0) begin errors++; $display("FAIL len0_reads: got %0d want 0", en_addr.size()); end
    checks++; if (first_vld >= 0) begin errors++; $display("FAIL len0_valid: got valid@%0d want none", first_vld); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 2) begin errors++; $display("FAIL len0_done: got n=%0d cyc=%0d want n=1 cyc=2", done_cyc.size(), done_cyc[0]); end
    checks++; if (busy_n != 1) begin errors++; $display("FAIL len0_busy: got %0d cycles want 1", busy_n); end
  endtask

  task automatic test_start_ignored();
    bit to;
    mem_ofs = 32'h100;
    do_xfer(10'h010, 16'd4, 0, 1'b1, to);
    checks++; if (to || en_addr.size() != 4 || hs_dat.size() != 4) begin errors++; $display("FAIL ign_count: got %0d reads %0d words want 4/4", en_addr.size(), hs_dat.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= hs_dat.size() || en_addr[i] !== m_addr(16, i) || hs_dat[i] !== m_word(16, i)) begin
        errors++; $display("FAIL ign_word[%0d]: got %h/%h want %h/%h", i, en_addr[i], hs_dat[i], m_addr(16, i), m_word(16, i));
      end
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin errors++; $display("FAIL ign_done: got n=%0d cyc=%0d want n=1 cyc=7", done_cyc.size(), done_cyc[0]); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    mem_ofs = 32'h100;
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    bus.i_start = 1'b1; bus.i_base_addr = 10'h010; bus.i_len = 16'd8; bus.i_dout_accep = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n = 0;
    while (hs_dat.size() < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (hs_dat.size() != 2) begin errors++; $display("FAIL rstmid_pre: got %0d words want 2", hs_dat.size()); end
    checks++; if (bus.o_dout_valid !== 1'b1 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_active: got valid=%b busy=%b want 1/1", bus.o_dout_valid, bus.o_busy); end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_bram_en !== 1'b0 || bus.o_dout_valid !== 1'b0 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got busy=%b done=%b en=%b vld=%b last=%b want all 0",
                         bus.o_busy, bus.o_done, bus.o_bram_en, bus.o_dout_valid, bus.o_last);
    end
    checks++; if (bus.o_dout !== '0 || bus.o_bram_addr !== '0) begin errors++; $display("FAIL rstmid_data: got dout=%h addr=%h want 0/0", bus.o_dout, bus.o_bram_addr); end
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    checks++; if (done_cyc.size() != 0) begin errors++; $display("FAIL rstmid_nodone: got %0d DONE pulses want 0", done_cyc.size()); end
    do_xfer(10'h020, 16'd3, 0, 1'b0, to);
    checks++; if (to || hs_dat.size() != 3) begin errors++; $display("FAIL rstmid_count: got %0d words to=%b want 3", hs_dat.size(), to); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= hs_dat.size() || hs_dat[i] !== m_word(32, i) || hs_last[i] !== (i == 2)) begin
        errors++; $display("FAIL rstmid_word[%0d]: got %h last=%b want %h last=%b", i, hs_dat[i], hs_last[i], m_word(32, i), (i == 2));
      end
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 6) begin errors++; $display("FAIL rstmid_done: got n=%0d cyc=%0d want n=1 cyc=6", done_cyc.size(), done_cyc[0]); end
  endtask

  task automatic test_random();
    bit to;
    int base, len, mode;
    for (int t = 0; t < 12; t++) begin
      base    = $urandom_range(0, 1023);
      len     = $urandom_range(1, 24);
      mode    = ($urandom_range(0, 1) == 0) ? 0 : 3;
      mem_ofs = $urandom;
      do_xfer(ADDR_W'(base), LEN_W'(len), mode, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: no DONE, want DONE", t); end
      checks++;
      if (en_addr.size() != len || hs_dat.size() != len) begin
        errors++; $display("FAIL rnd%0d_count: got %0d reads %0d words want %0d", t, en_addr.size(), hs_dat.size(), len);
      end
      for (int i = 0; i < len; i++) begin
        checks++;
        if (i >= hs_dat.size() || hs_dat[i] !== m_word(base, i) || hs_last[i] !== (i == len - 1)) begin
          errors++; $display("FAIL rnd%0d_word[%0d]: got %h last=%b want %h last=%b", t, i, hs_dat[i], hs_last[i], m_word(base, i), (i == len - 1));
        end
        if (mode == 0) begin
          checks++;
          if (i >= hs_cyc.size() || hs_cyc[i] != 3 + i) begin
            errors++; $display("FAIL rnd%0d_rate[%0d]: got cycle %0d want %0d", t, i, hs_cyc[i], 3 + i);
          end
        end
      end
      checks++;
      if (done_cyc.size() != 1 || hs_cyc.size() != len || done_cyc[0] != hs_cyc[len - 1] + 1) begin
        errors++; $display("FAIL rnd%0d_done: got n=%0d cyc=%0d want one, after last handshake", t, done_cyc.size(), done_cyc[0]);
      end
      checks++;
      if (max_ahead > 2 || stab_viol != 0 || last_stray != 0) begin
        errors++; $display("FAIL rnd%0d_flow: got ahead=%0d stab=%0d stray=%0d want <=2/0/0", t, max_ahead, stab_viol, last_stray);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_start      = 1'b0;
    bus.i_base_addr  = '0;
    bus.i_len        = '0;
    bus.i_dout_accep = 1'b0;
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_wrap();
    test_len0();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
